// File: rtl/scl_timing_gen_pkg.sv
// scl_timing_gen_pkg: shared FSM state encoding and default sizing for the SCL generator
package scl_timing_gen_pkg;
  localparam int DEF_DIV_W = 12;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TO_W = 16;
  typedef enum logic [2:0] {ST_IDLE, ST_RELEASE, ST_HIGH, ST_LOW, ST_HOLD} state_t;
endpackage

// File: rtl/scl_timing_gen_bit_sync.sv
// bit_sync: N-stage synchroniser for an asynchronous input; resets to 1 (released bus)
module bit_sync #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [N-1:0] r_ff;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_ff <= '1;
    else r_ff <= {r_ff[N-2:0], i_d};
  assign o_q = r_ff[N-1];
endmodule

// File: rtl/scl_timing_gen.sv
// scl_timing_gen: master-mode SCL generator with independent high/low phases,
// multi-master clock sync, stretch detection and sticky stretch timeout.
module scl_timing_gen
  import scl_timing_gen_pkg::*;
#(
  parameter int DIV_W       = DEF_DIV_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TO_W        = DEF_TO_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_scl_en,
  input  logic             i_scl_wait,
  input  logic [DIV_W-1:0] i_thigh,
  input  logic [DIV_W-1:0] i_tlow,
  input  logic [TO_W-1:0]  i_to_limit,
  input  logic             i_scl_i,
  output logic             o_scl_o,
  output logic [DIV_W-1:0] o_thigh_cur,
  output logic [DIV_W-1:0] o_tlow_cur,
  output logic             o_scl_rise_p,
  output logic             o_scl_fall_p,
  output logic             o_scl_sync_p,
  output logic             o_scl_stretched,
  output logic             o_scl_timeout
);
  state_t           r_state, w_nxt;
  logic [DIV_W-1:0] r_cnt, w_cnt, r_thigh_cur, r_tlow_cur;
  logic [TO_W-1:0]  r_rel, w_rel, w_rel_inc;
  logic             r_timeout, w_timeout, r_rise, w_rise, r_fall, w_fall, r_sync, w_sync, w_scl_s;

  bit_sync #(.N(SYNC_STAGES)) u_sync (.clk(clk), .rst(rst), .i_d(i_scl_i), .o_q(w_scl_s));

  assign w_rel_inc = (r_rel == '1) ? r_rel : r_rel + 1'b1;

  always_comb begin
    w_nxt = r_state;
    w_cnt = r_cnt;
    w_rel = r_rel;
    w_timeout = r_timeout;
    w_rise = 1'b0;
    w_fall = 1'b0;
    w_sync = 1'b0;
    if (!i_scl_en) begin
      w_nxt = ST_IDLE;
      w_cnt = '0;
      w_rel = '0;
      w_timeout = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (!r_timeout) begin
          w_nxt = ST_RELEASE;
          w_rel = '0;
        end
        ST_RELEASE: begin
          w_rel = w_rel_inc;
          // bus high confirmed beats a timeout landing on the same clock
          if (w_scl_s) begin
            w_nxt = ST_HIGH;
            w_cnt = '0;
            w_rise = 1'b1;
          end else if (i_to_limit != '0 && w_rel_inc == i_to_limit) begin
            w_nxt = ST_IDLE;
            w_timeout = 1'b1;
          end
        end
        ST_HIGH: begin
          w_cnt = r_cnt + 1'b1;
          if (r_cnt == r_thigh_cur || !w_scl_s) begin
            w_nxt = ST_LOW;
            w_cnt = '0;
            w_fall = 1'b1;
            w_sync = r_cnt != r_thigh_cur;
          end
        end
        ST_LOW: begin
          w_cnt = r_cnt + 1'b1;
          if (r_cnt == r_tlow_cur) begin
            w_nxt = i_scl_wait ? ST_HOLD : ST_RELEASE;
            w_cnt = '0;
            w_rel = '0;
          end
        end
        ST_HOLD: if (!i_scl_wait) begin
          w_nxt = ST_RELEASE;
          w_rel = '0;
        end
        default: w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_rel <= '0;
      r_timeout <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      r_sync <= 1'b0;
      r_thigh_cur <= DIV_W'(1);
      r_tlow_cur <= DIV_W'(1);
    end else begin
      r_state <= w_nxt;
      r_cnt <= w_cnt;
      r_rel <= w_rel;
      r_timeout <= w_timeout;
      r_rise <= w_rise;
      r_fall <= w_fall;
      r_sync <= w_sync;
      if (!i_scl_en) begin
        r_thigh_cur <= (i_thigh == '0) ? DIV_W'(1) : i_thigh;
        r_tlow_cur <= (i_tlow == '0) ? DIV_W'(1) : i_tlow;
      end
    end

  assign o_scl_o = !(r_state == ST_LOW || r_state == ST_HOLD);
  assign o_scl_stretched = (r_state == ST_RELEASE) && (r_rel > TO_W'(SYNC_STAGES));
  assign o_thigh_cur = r_thigh_cur;
  assign o_tlow_cur = r_tlow_cur;
  assign o_scl_rise_p = r_rise;
  assign o_scl_fall_p = r_fall;
  assign o_scl_sync_p = r_sync;
  assign o_scl_timeout = r_timeout;
endmodule
